led_sequence_controller: RTL and testbench
==========================================

LED_SEQUENCE_CONTROLLER -- requirements
Module: led_sequence_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port tick, input, 1 bit: one-cycle step strobe from the clock divider; all stepping occurs only on cycles with tick=1.
REQ-004 SHALL have port start_btn, input, 1 bit: debounced one-cycle start/resume pulse.
REQ-005 SHALL have port stop_btn, input, 1 bit: debounced one-cycle pause/cancel pulse.
REQ-006 SHALL have port door_open, input, 1 bit: door-sensor level, 1 = open.
REQ-007 SHALL have port mode_sel, input, 2 bits: requested display mode, sampled only at start from IDLE.
REQ-008 SHALL have port cook_time, input, 8 bits: cook duration in ticks, sampled only at start from IDLE.
REQ-009 SHALL have port I, output, 4 bits: LED index to the 4-to-16 decoder.
REQ-010 SHALL have port mode, output, 2 bits: decoder mode.
REQ-011 SHALL have port start, output, 1 bit: decoder start; 1 only in RUN.
REQ-012 SHALL have port idle, output, 1 bit: decoder idle; 1 only in IDLE.
REQ-013 SHALL have port remaining, output, 8 bits: ticks left.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-016 IDLE->RUN SHALL occur when start_btn=1, door_open=0 and cook_time!=0; on that edge: remaining<=cook_time, mode latch<=mode_sel, I<=0.
REQ-017 start_btn in IDLE with cook_time=0 or door_open=1 SHALL be ignored; the block stays in IDLE.
REQ-018 In RUN, each tick SHALL do I<=I+1 mod 16 (15 wraps to 0) and remaining<=remaining-1.
REQ-019 In RUN, a tick with remaining=1 SHALL move to DONE with remaining=0; done=1 for exactly the next cycle.
REQ-020 In RUN, door_open=1 or stop_btn=1 SHALL move to PAUSE; a tick in the same cycle is discarded (I and remaining unchanged).
REQ-021 In PAUSE, I and remaining SHALL hold; start_btn with door_open=0 returns to RUN; stop_btn returns to IDLE; stop_btn wins when both are asserted.
REQ-022 DONE SHALL last exactly DONE_TICKS=3 ticks, then enter IDLE; stop_btn in DONE enters IDLE immediately; start_btn in DONE is ignored.
REQ-023 Output mapping: IDLE -> I=0, mode=0, remaining=0; RUN/PAUSE -> mode=latched mode_sel; DONE -> mode=3, I=15.
REQ-024 remaining SHALL never underflow below 0.

Reset
REQ-025 While rst_n=0: state=IDLE, I=0, mode=0, start=0, idle=1, remaining=0, done=0, regardless of clk.
REQ-026 Reset asserted mid-RUN SHALL abandon the cycle; after release the block waits in IDLE for a new start_btn.

Structure
REQ-027 The shared package microwave_pkg SHALL hold the state enumeration, DONE_TICKS=3, and the widths IDX_W=4, TIME_W=8, MODE_W=2.
REQ-028 The tick-gated load/decrement of remaining SHALL be one sub-module, cook_down_counter (inputs: load, value, dec; output: count; output zero_next when count=1 and dec=1).

Verification
REQ-029 Reset, then start_btn with cook_time=5, mode_sel=1, and 5 ticks -> I steps 0..5, remaining goes 5->0, one done pulse, start=1 only during RUN.
REQ-030 cook_time=20 -> I wraps 15->0 at tick 16 and ends at I=4 on entering DONE.
REQ-031 cook_time=10, door_open=1 at the same cycle as tick 4 -> PAUSE with remaining=7; after door closes and start_btn, 7 more ticks reach DONE.
REQ-032 In PAUSE, start_btn and stop_btn asserted together -> IDLE with idle=1, remaining=0.
REQ-033 start_btn with cook_time=0, and separately with door_open=1 -> block stays in IDLE, no output change.
REQ-034 rst_n=0 asynchronously mid-RUN with remaining=3 -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave LED sequence controller.
package microwave_pkg;

  // Datapath widths.
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TIME_W = 8;
  localparam int unsigned MODE_W = 2;

  // Number of ticks the DONE display is held before returning to IDLE.
  localparam int unsigned DONE_TICKS = 3;
  localparam int unsigned DONE_CNT_W = $clog2(DONE_TICKS);

  // Decoder settings shown while in DONE.
  localparam logic [MODE_W-1:0] DONE_MODE = MODE_W'(3);
  localparam logic [IDX_W-1:0]  DONE_IDX  = IDX_W'(15);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  // True on the DONE tick that completes the hold period.
  function automatic logic done_hold_last(input logic [DONE_CNT_W-1:0] cnt);
    return cnt == DONE_CNT_W'(DONE_TICKS - 1);
  endfunction

endpackage

// File: rtl/cook_down_counter.sv
// Loadable down-counter holding the ticks left in the current cook cycle.
// Saturates at zero; load has priority over decrement.
module cook_down_counter
  import microwave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] value,
  input  logic              dec,
  output logic [TIME_W-1:0] count,
  output logic              zero_next
);

  logic [TIME_W-1:0] count_q, count_d;

  // Next count: load, else saturating decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TIME_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  // This decrement lands on zero.
  assign zero_next = dec && (count_q == TIME_W'(1));

endmodule

// File: rtl/led_sequence_controller.sv
// Cook-cycle sequencer driving a 4-to-16 LED decoder. Steps the LED index on
// each tick while running, supports pause/resume on door or stop button, and
// shows a fixed completion pattern for a few ticks before going idle.
module led_sequence_controller
  import microwave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              door_open,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic [TIME_W-1:0] cook_time,
  output logic [IDX_W-1:0]  I,
  output logic [MODE_W-1:0] mode,
  output logic              start,
  output logic              idle,
  output logic [TIME_W-1:0] remaining,
  output logic              done
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic                  start_q, start_d;
  logic                  idle_q, idle_d;
  logic                  done_q, done_d;
  logic [DONE_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              cnt_load;
  logic [TIME_W-1:0] cnt_value;
  logic              cnt_dec;
  logic              cnt_zero_next;
  logic [TIME_W-1:0] cnt_count;

  cook_down_counter u_cook_down_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .value     (cnt_value),
    .dec       (cnt_dec),
    .count     (cnt_count),
    .zero_next (cnt_zero_next)
  );

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_btn && !door_open && (cook_time != '0)) begin
          state_d   = StRun;
          idx_d     = '0;
          mode_d    = mode_sel;
          cnt_load  = 1'b1;
          cnt_value = cook_time;
        end
      end

      StRun: begin
        // A pause request wins over a coincident tick; that tick is dropped.
        if (door_open || stop_btn) begin
          state_d = StPause;
        end else if (tick) begin
          cnt_dec = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (cnt_zero_next) begin
            state_d    = StDone;
            mode_d     = DONE_MODE;
            done_d     = 1'b1;
            hold_cnt_d = '0;
          end
        end
      end

      StPause: begin
        if (stop_btn) begin
          state_d   = StIdle;
          idx_d     = '0;
          mode_d    = '0;
          cnt_load  = 1'b1;
          cnt_value = '0;
        end else if (start_btn && !door_open) begin
          state_d = StRun;
        end
      end

      StDone: begin
        // The entry cycle still shows the final step index; the fixed
        // completion index takes over from the following cycle.
        idx_d = DONE_IDX;
        if (stop_btn || (tick && done_hold_last(hold_cnt_q))) begin
          state_d   = StIdle;
          idx_d     = '0;
          mode_d    = '0;
          cnt_load  = 1'b1;
          cnt_value = '0;
        end else if (tick) begin
          hold_cnt_d = hold_cnt_q + DONE_CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    start_d = (state_d == StRun);
    idle_d  = (state_d == StIdle);
  end

  // State and registered decoder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      mode_q     <= '0;
      start_q    <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      idle_q     <= idle_d;
      done_q     <= done_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign I         = idx_q;
  assign mode      = mode_q;
  assign start     = start_q;
  assign idle      = idle_q;
  assign remaining = cnt_count;
  assign done      = done_q;

endmodule

// File: tb/tb_led_sequence_controller.sv
// Bench for led_sequence_controller: vector table, directed corner cases and
// randomized stimulus compared against a behavioural model.
module tb_led_sequence_controller;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start_btn;
  logic       stop_btn;
  logic       door_open;
  logic [1:0] mode_sel;
  logic [7:0] cook_time;
  logic [3:0] dut_i;
  logic [1:0] dut_mode;
  logic       dut_start;
  logic       dut_idle;
  logic [7:0] dut_rem;
  logic       dut_done;

  int n_cmp = 0;
  int n_err = 0;

  led_sequence_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .door_open (door_open),
    .mode_sel  (mode_sel),
    .cook_time (cook_time),
    .I         (dut_i),
    .mode      (dut_mode),
    .start     (dut_start),
    .idle      (dut_idle),
    .remaining (dut_rem),
    .done      (dut_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0=idle 1=run 2=pause 3=done.
  int m_phase, m_total, m_left, m_mode, m_hold, m_age;
  bit m_pulse;

  task automatic model_reset();
    m_phase = 0; m_total = 0; m_left = 0; m_mode = 0;
    m_hold = 0; m_age = 0; m_pulse = 0;
  endtask

  task automatic model_update();
    m_pulse = 0;
    case (m_phase)
      0: if (start_btn && !door_open && cook_time != 0) begin
        m_phase = 1; m_total = int'(cook_time); m_left = m_total; m_mode = int'(mode_sel);
      end
      1: if (door_open || stop_btn) m_phase = 2;
         else if (tick) begin
           m_left = m_left - 1;
           if (m_left == 0) begin
             m_phase = 3; m_pulse = 1; m_hold = 0; m_age = 0;
           end
         end
      2: if (stop_btn) m_phase = 0;
         else if (start_btn && !door_open) m_phase = 1;
      default: begin
        m_age++;
        if (stop_btn) m_phase = 0;
        else if (tick) begin
          m_hold++;
          if (m_hold == 3) m_phase = 0;
        end
      end
    endcase
  endtask

  function automatic int exp_i();
    if (m_phase == 0) return 0;
    if (m_phase == 3) return (m_age == 0) ? (m_total % 16) : 15;
    return (m_total - m_left) % 16;
  endfunction

  function automatic int exp_mode();
    if (m_phase == 0) return 0;
    if (m_phase == 3) return 3;
    return m_mode;
  endfunction

  function automatic int exp_rem();
    return (m_phase == 1 || m_phase == 2) ? m_left : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("model.I", int'(dut_i), exp_i());
    chk("model.mode", int'(dut_mode), exp_mode());
    chk("model.remaining", int'(dut_rem), exp_rem());
    chk("model.start", int'(dut_start), (m_phase == 1) ? 1 : 0);
    chk("model.idle", int'(dut_idle), (m_phase == 0) ? 1 : 0);
    chk("model.done", int'(dut_done), m_pulse ? 1 : 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".I"}, int'(dut_i), 0);
    chk({tag, ".mode"}, int'(dut_mode), 0);
    chk({tag, ".start"}, int'(dut_start), 0);
    chk({tag, ".idle"}, int'(dut_idle), 1);
    chk({tag, ".remaining"}, int'(dut_rem), 0);
    chk({tag, ".done"}, int'(dut_done), 0);
  endtask

  // One clock: update the model on the edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk_model();
  endtask

  task automatic drive(input logic st, input logic sp, input logic dr, input logic tk,
                       input logic [1:0] ms, input logic [7:0] ct);
    start_btn = st; stop_btn = sp; door_open = dr; tick = tk; mode_sel = ms; cook_time = ct;
  endtask

  typedef struct {
    logic       st, sp, dr, tk;
    logic [1:0] ms;
    logic [7:0] ct;
    int         e_i, e_rem, e_mode;
    int         e_start, e_idle, e_done;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sp, input logic dr, input logic tk,
                              input logic [1:0] ms, input logic [7:0] ct, input int e_i,
                              input int e_rem, input int e_mode, input int e_start,
                              input int e_idle, input int e_done);
    vec_t v;
    v.st = st; v.sp = sp; v.dr = dr; v.tk = tk; v.ms = ms; v.ct = ct;
    v.e_i = e_i; v.e_rem = e_rem; v.e_mode = e_mode;
    v.e_start = e_start; v.e_idle = e_idle; v.e_done = e_done;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    // Basic 5-tick cycle, DONE hold, then ignored starts in IDLE.
    //               st sp dr tk ms ct   I rem md  s  i  d
    vecs[0]  = mk(1, 0, 0, 0, 1, 5,   0, 5, 1,  1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0,   1, 4, 1,  1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0,   2, 3, 1,  1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0,   3, 2, 1,  1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 0,   4, 1, 1,  1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0,   5, 0, 3,  0, 0, 1);
    vecs[6]  = mk(1, 0, 0, 0, 0, 7,  15, 0, 3,  0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 0,  15, 0, 3,  0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0,  15, 0, 3,  0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 0,  0, 1, 0);
    vecs[10] = mk(1, 0, 0, 1, 2, 0,   0, 0, 0,  0, 1, 0);
    vecs[11] = mk(1, 0, 1, 1, 2, 5,   0, 0, 0,  0, 1, 0);

    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].st, vecs[k].sp, vecs[k].dr, vecs[k].tk, vecs[k].ms, vecs[k].ct);
      step();
      chk($sformatf("vec%0d.I", k), int'(dut_i), vecs[k].e_i);
      chk($sformatf("vec%0d.remaining", k), int'(dut_rem), vecs[k].e_rem);
      chk($sformatf("vec%0d.mode", k), int'(dut_mode), vecs[k].e_mode);
      chk($sformatf("vec%0d.start", k), int'(dut_start), vecs[k].e_start);
      chk($sformatf("vec%0d.idle", k), int'(dut_idle), vecs[k].e_idle);
      chk($sformatf("vec%0d.done", k), int'(dut_done), vecs[k].e_done);
    end

    // Index wrap: cook_time=20 wraps at tick 16 and enters DONE with I=4.
    drive(1, 0, 0, 0, 2, 20);
    step();
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) chk("wrap.i15", int'(dut_i), 15);
      if (k == 16) chk("wrap.i16", int'(dut_i), 0);
      if (k == 20) begin
        chk("wrap.i_done", int'(dut_i), 4);
        chk("wrap.done", int'(dut_done), 1);
      end
    end
    drive(0, 1, 0, 0, 0, 0);  // stop in DONE exits at once
    step();
    chk("done_stop.idle", int'(dut_idle), 1);

    // Door opened with tick 4 pauses at remaining=7; resume and finish.
    drive(1, 0, 0, 0, 3, 10);
    step();
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) step();
    drive(0, 0, 1, 1, 0, 0);
    step();
    chk("pause.remaining", int'(dut_rem), 7);
    chk("pause.start", int'(dut_start), 0);
    chk("pause.idle", int'(dut_idle), 0);
    step();
    step();
    chk("pause.hold", int'(dut_rem), 7);
    drive(0, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("resume.start", int'(dut_start), 1);
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) step();
    chk("resume.done", int'(dut_done), 1);
    chk("resume.rem", int'(dut_rem), 0);
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step();
    chk("resume.idle", int'(dut_idle), 1);

    // Start and stop together in PAUSE: stop wins.
    drive(1, 0, 0, 0, 1, 9);
    step();
    drive(0, 0, 0, 1, 0, 0);
    step();
    step();
    drive(0, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    chk("both.idle", int'(dut_idle), 1);
    chk("both.remaining", int'(dut_rem), 0);

    // Asynchronous reset mid-RUN with remaining=3.
    drive(1, 0, 0, 0, 2, 6);
    step();
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step();
    chk("prereset.remaining", int'(dut_rem), 3);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step();
    chk("after_reset.idle", int'(dut_idle), 1);

    // Randomized stimulus against the model.
    for (int k = 0; k < 1500; k++) begin
      start_btn = ($urandom_range(0, 7) == 0);
      stop_btn  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) door_open = ~door_open;
      tick      = ($urandom_range(0, 1) == 1);
      mode_sel  = 2'($urandom_range(0, 3));
      cook_time = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
